mdu_issue_ctrl: RTL and testbench

- Execute-stage initiator for the multi-cycle multiply/divide unit. It is the requesting end of the MDU req/ack/cnt handshake.
- Takes one MDU instruction from EX, latches its operands, and drives the request to the MDU.
- Stalls the pipeline while the MDU is busy, captures the MDU result and condition bits, and presents one write-back beat with GPR, CR0 and XER[OV] write enables.
- Also handles flushes and an MDU timeout.

---
 rtl/mdu_issue_ctrl_if.sv | 34 +++
 rtl/mdu_issue_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_issue_ctrl_if.sv
// MDU request/ack bundle between the EX-stage issue controller (master)
// and the multi-cycle multiply/divide unit (slave).
//
// Handshake: the master raises mdu_req with mdu_a/mdu_b/mdu_op stable.
// The request is taken on the rising edge where mdu_req && mdu_ack. The
// master must then drop mdu_req, because the MDU re-latches the opcode on
// every cycle that mdu_req is high. The first later cycle with mdu_ack=1 is
// completion, and mdu_c/mdu_d are valid only in that cycle. mdu_cnt is the
// MDU's remaining-cycle count and is for observation only.
interface mdu_issue_ctrl_if #(
    parameter int ARCH_WIDTH  = 32,
    parameter int MDUOP_WIDTH = 3,
    parameter int MDU_D_WIDTH = 4,
    parameter int CNT_WIDTH   = 4
);
    logic                   mdu_req;
    logic [ARCH_WIDTH-1:0]  mdu_a;
    logic [ARCH_WIDTH-1:0]  mdu_b;
    logic [MDUOP_WIDTH-1:0] mdu_op;
    logic                   mdu_ack;
    logic [CNT_WIDTH-1:0]   mdu_cnt;
    logic [ARCH_WIDTH-1:0]  mdu_c;
    logic [MDU_D_WIDTH-1:0] mdu_d;

    modport master (
        output mdu_req, mdu_a, mdu_b, mdu_op,
        input  mdu_ack, mdu_cnt, mdu_c, mdu_d
    );

    modport slave (
        input  mdu_req, mdu_a, mdu_b, mdu_op,
        output mdu_ack, mdu_cnt, mdu_c, mdu_d
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// EX-stage initiator for the multi-cycle MDU: latches one instruction,
// requests the MDU, stalls the pipe while it works, and emits a single
// write-back beat with GPR/CR0/XER[OV] enables. Handles flush and timeout.
// Status bits are indexed d[0]=OV, d[1]=LT, d[2]=GT, d[3]=EQ.
module mdu_issue_ctrl #(
    parameter int ARCH_WIDTH  = 32,
    parameter int MDUOP_WIDTH = 3,
    parameter int MDU_D_WIDTH = 4,
    parameter int CNT_WIDTH   = 4,
    parameter int RADDR_WIDTH = 5,
    parameter int MAX_WAIT    = 64,
    parameter logic [MDUOP_WIDTH-1:0] MDUOP_NOP = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    input  logic [MDUOP_WIDTH-1:0] ex_op,
    input  logic [ARCH_WIDTH-1:0]  ex_a,
    input  logic [ARCH_WIDTH-1:0]  ex_b,
    input  logic [RADDR_WIDTH-1:0] ex_rd,
    input  logic                   ex_rc,
    input  logic                   ex_oe,
    input  logic                   flush,
    input  logic                   xer_so,
    mdu_issue_ctrl_if.master       mdu,
    output logic                   stall,
    output logic                   wb_valid,
    output logic [RADDR_WIDTH-1:0] wb_rd,
    output logic [ARCH_WIDTH-1:0]  wb_data,
    output logic                   cr0_we,
    output logic [3:0]             cr0_data,
    output logic                   ov_we,
    output logic                   ov_data,
    output logic                   timeout_err,
    output logic [2:0]             dbg_state,
    output logic [CNT_WIDTH-1:0]   dbg_mdu_cnt
);

    localparam int WCNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [WCNT_W-1:0]      wcnt_inc;
    logic [MDUOP_WIDTH-1:0] op_q;
    logic [ARCH_WIDTH-1:0]  a_q, b_q, c_q;
    logic [RADDR_WIDTH-1:0] rd_q;
    logic                   rc_q, oe_q;
    logic [MDU_D_WIDTH-1:0] d_q;
    logic                   issue_go, capture_go, timeout_hit;

    // Wait counter saturates at the timeout value; timeout only while an op is outstanding.
    assign wcnt_inc    = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 1'b1;
    assign timeout_hit = ((state_q == S_WAIT) || (state_q == S_DRAIN)) &&
                         !mdu.mdu_ack && (wcnt_q == WCNT_MAX);

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state: issue, accept, complete, drain, and timeout decisions.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        issue_go   = 1'b0;
        capture_go = 1'b0;
        case (state_q)
            S_IDLE: begin
                wcnt_d = '0;
                if (ex_valid && !flush) begin
                    issue_go = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (mdu.mdu_ack) begin
                    // Accepted even under flush: the MDU is now busy, so drain it.
                    wcnt_d  = '0;
                    state_d = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_inc;
                if (mdu.mdu_ack) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        capture_go = 1'b1;
                        state_d    = S_DONE;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                wcnt_d = wcnt_inc;
                if (mdu.mdu_ack || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                wcnt_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                wcnt_d  = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Instruction latches on issue; result and status capture on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= MDUOP_NOP;
            a_q  <= '0;
            b_q  <= '0;
            rd_q <= '0;
            rc_q <= 1'b0;
            oe_q <= 1'b0;
            c_q  <= '0;
            d_q  <= '0;
        end else begin
            if (issue_go) begin
                op_q <= ex_op;
                a_q  <= ex_a;
                b_q  <= ex_b;
                rd_q <= ex_rd;
                rc_q <= ex_rc;
                oe_q <= ex_oe;
            end
            if (capture_go) begin
                c_q <= mdu.mdu_c;
                d_q <= mdu.mdu_d;
            end
        end
    end

    // Outputs: request in REQ, stall while busy, one write-back beat in DONE.
    always_comb begin
        mdu.mdu_req = 1'b0;
        stall       = 1'b0;
        wb_valid    = 1'b0;
        cr0_we      = 1'b0;
        cr0_data    = 4'b0000;
        ov_we       = 1'b0;
        ov_data     = 1'b0;
        timeout_err = timeout_hit;
        case (state_q)
            S_IDLE:  stall = ex_valid && !flush;
            S_REQ: begin
                mdu.mdu_req = 1'b1;
                stall       = 1'b1;
            end
            S_WAIT:  stall = 1'b1;
            S_DRAIN: stall = 1'b1;
            S_DONE: begin
                wb_valid = 1'b1;
                cr0_we   = rc_q;
                cr0_data = {d_q[1], d_q[2], d_q[3], xer_so};
                ov_we    = oe_q;
                ov_data  = d_q[0];
            end
            default: stall = 1'b0;
        endcase
    end

    assign mdu.mdu_a   = a_q;
    assign mdu.mdu_b   = b_q;
    assign mdu.mdu_op  = op_q;
    assign wb_rd       = rd_q;
    assign wb_data     = c_q;
    assign dbg_state   = state_q;
    assign dbg_mdu_cnt = mdu.mdu_cnt;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: behavioural MDU model, table of directed
// operations with hand-computed results, and hand-written flush, timeout
// and mid-operation reset sequences.
module tb_mdu_issue_ctrl;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_MULW   = 3'd1;
  localparam logic [2:0] OP_MULHW  = 3'd2;
  localparam logic [2:0] OP_MULHWU = 3'd3;
  localparam logic [2:0] OP_DIVW   = 3'd4;
  localparam logic [2:0] OP_DIVWU  = 3'd5;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rc;
    logic        oe;
    logic        so;
    int          busy;      // MDU cycles with ack=0 after acceptance
    int          busy_pre;  // cycles (from issue) the MDU is held busy beforehand
    logic [31:0] e_data;
    logic [3:0]  e_cr0;
    logic        e_ov;
    int          e_stall;
    int          e_req;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ex_valid, ex_rc, ex_oe, flush, xer_so;
  logic [2:0]  ex_op;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_rd;
  logic        stall, wb_valid, cr0_we, ov_we, ov_data, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  cr0_data;
  logic [2:0]  dbg_state;
  logic [3:0]  dbg_mdu_cnt;

  mdu_issue_ctrl_if #(.ARCH_WIDTH(32), .MDUOP_WIDTH(3), .MDU_D_WIDTH(4), .CNT_WIDTH(4)) mif ();

  mdu_issue_ctrl #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_rc(ex_rc), .ex_oe(ex_oe), .flush(flush), .xer_so(xer_so),
    .mdu(mif), .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .cr0_we(cr0_we), .cr0_data(cr0_data), .ov_we(ov_we), .ov_data(ov_data),
    .timeout_err(timeout_err), .dbg_state(dbg_state), .dbg_mdu_cnt(dbg_mdu_cnt)
  );

  // ---------------- MDU model ----------------
  int          cur_busy;
  logic        ext_busy;
  logic [3:0]  mdl_cnt;
  logic [2:0]  mdl_op;
  logic [31:0] mdl_a, mdl_b;
  logic [35:0] mdl_res;

  // Returns {EQ, GT, LT, OV, result}, i.e. d[3:0] then c.
  function automatic logic [35:0] mdu_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] up;
    logic [31:0] r;
    logic ov;
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    up = {32'd0, a} * {32'd0, b};
    r  = '0;
    ov = 1'b0;
    case (op)
      OP_MULW:   begin r = sp[31:0]; ov = (sp[63:31] != {33{sp[31]}}); end
      OP_MULHW:  r = sp[63:32];
      OP_MULHWU: r = up[63:32];
      OP_DIVW: begin
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ov = 1'b1;
        else r = $signed(a) / $signed(b);
      end
      OP_DIVWU: begin
        if (b == 32'd0) ov = 1'b1;
        else r = a / b;
      end
      default: r = '0;
    endcase
    return {(r == 32'd0), (!r[31] && r != 32'd0), r[31], ov, r};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mdl_cnt <= 4'd0;
      mdl_op  <= OP_NOP;
      mdl_a   <= '0;
      mdl_b   <= '0;
    end else if (mif.mdu_req && mif.mdu_ack) begin
      mdl_cnt <= 4'(cur_busy);
      mdl_op  <= mif.mdu_op;
      mdl_a   <= mif.mdu_a;
      mdl_b   <= mif.mdu_b;
    end else if (mdl_cnt != 4'd0) begin
      mdl_cnt <= mdl_cnt - 4'd1;
    end
  end

  assign mdl_res     = mdu_calc(mdl_op, mdl_a, mdl_b);
  assign mif.mdu_ack = (mdl_cnt == 4'd0) && !ext_busy;
  assign mif.mdu_cnt = mdl_cnt;
  // Outside the completion cycle the result lines carry garbage.
  assign mif.mdu_c   = mif.mdu_ack ? mdl_res[31:0] : ~mdl_res[31:0];
  assign mif.mdu_d   = mif.mdu_ack ? mdl_res[35:32] : ~mdl_res[35:32];

  // ---------------- monitor / scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  int stall_tot = 0, req_tot = 0, wb_tot = 0, cr0we_tot = 0, ovwe_tot = 0, to_tot = 0;
  int opnd_bad = 0;
  logic [31:0] exp_a, exp_b;
  logic [2:0]  exp_op;
  logic [31:0] last_wb_data;
  logic [4:0]  last_wb_rd;
  logic [3:0]  last_cr0_data;
  logic        last_cr0_we, last_ov_we, last_ov_data, last_wb_stall;

  always @(negedge clk) begin
    if (stall) stall_tot++;
    if (mif.mdu_req) begin
      req_tot++;
      if (mif.mdu_a !== exp_a || mif.mdu_b !== exp_b || mif.mdu_op !== exp_op) opnd_bad++;
    end
    if (cr0_we) cr0we_tot++;
    if (ov_we) ovwe_tot++;
    if (timeout_err) to_tot++;
    if (wb_valid) begin
      wb_tot++;
      last_wb_data  = wb_data;
      last_wb_rd    = wb_rd;
      last_cr0_we   = cr0_we;
      last_cr0_data = cr0_data;
      last_ov_we    = ov_we;
      last_ov_data  = ov_data;
      last_wb_stall = stall;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mdu_req"}, 32'(mif.mdu_req), 32'd0);
    chk({tag, "_mdu_a"}, mif.mdu_a, 32'd0);
    chk({tag, "_mdu_b"}, mif.mdu_b, 32'd0);
    chk({tag, "_mdu_op"}, 32'(mif.mdu_op), 32'(OP_NOP));
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_cr0_we"}, 32'(cr0_we), 32'd0);
    chk({tag, "_cr0_data"}, 32'(cr0_data), 32'd0);
    chk({tag, "_ov_we"}, 32'(ov_we), 32'd0);
    chk({tag, "_ov_data"}, 32'(ov_data), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic drive_ex(input vec_t v);
    ex_op = v.op; ex_a = v.a; ex_b = v.b; ex_rd = v.rd; ex_rc = v.rc; ex_oe = v.oe;
    xer_so = v.so; ex_valid = 1'b1;
    exp_a = v.a; exp_b = v.b; exp_op = v.op;
    cur_busy = v.busy;
  endtask

  // Full operation: issue, wait (bounded) for the write-back beat, check it.
  task automatic run_vec(input vec_t v, input string tag);
    int s_stall, s_req, s_wb, s_bad, cyc;
    s_stall = stall_tot; s_req = req_tot; s_wb = wb_tot; s_bad = opnd_bad;
    @(posedge clk); #1;
    drive_ex(v);
    ext_busy = (v.busy_pre > 0);
    cyc = 0;
    while (wb_tot == s_wb && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
      @(posedge clk); #1;
      if (cyc >= v.busy_pre) ext_busy = 1'b0;
    end
    ex_valid = 1'b0;
    ext_busy = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_wb_beats"}, 32'(wb_tot - s_wb), 32'd1);
    chk({tag, "_wb_data"}, last_wb_data, v.e_data);
    chk({tag, "_wb_rd"}, 32'(last_wb_rd), 32'(v.rd));
    chk({tag, "_cr0_we"}, 32'(last_cr0_we), 32'(v.rc));
    chk({tag, "_cr0_data"}, 32'(last_cr0_data), 32'(v.e_cr0));
    chk({tag, "_ov_we"}, 32'(last_ov_we), 32'(v.oe));
    chk({tag, "_ov_data"}, 32'(last_ov_data), 32'(v.e_ov));
    chk({tag, "_stall_cycles"}, 32'(stall_tot - s_stall), 32'(v.e_stall));
    chk({tag, "_req_cycles"}, 32'(req_tot - s_req), 32'(v.e_req));
    chk({tag, "_operands_stable"}, 32'(opnd_bad - s_bad), 32'd0);
    chk({tag, "_done_stall"}, 32'(last_wb_stall), 32'd0);
  endtask

  // Fixed-length sequence with scripted MDU-busy, flush and EX-drop cycles.
  task automatic run_seq(input vec_t v, input int busy_pre, input int busy_from,
                         input int flush_at, input int drop_at, input int total,
                         output int d_stall, output int d_req, output int d_wb,
                         output int d_cr0, output int d_ov, output int d_to,
                         output int to_cyc, output logic [2:0] last_state,
                         output logic last_stall);
    int s_stall, s_req, s_wb, s_cr0, s_ov, s_to;
    s_stall = stall_tot; s_req = req_tot; s_wb = wb_tot;
    s_cr0 = cr0we_tot; s_ov = ovwe_tot; s_to = to_tot;
    to_cyc = -1;
    last_state = 3'd7;
    last_stall = 1'b1;
    @(posedge clk); #1;
    drive_ex(v);
    for (int cyc = 0; cyc < total; cyc++) begin
      ext_busy = (cyc < busy_pre) || (cyc >= busy_from);
      flush    = (cyc == flush_at);
      if (drop_at >= 0 && cyc >= drop_at) ex_valid = 1'b0;
      @(negedge clk); #1;
      if (timeout_err && to_cyc < 0) to_cyc = cyc;
      last_state = dbg_state;
      last_stall = stall;
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    flush    = 1'b0;
    ext_busy = 1'b0;
    d_stall = stall_tot - s_stall; d_req = req_tot - s_req; d_wb = wb_tot - s_wb;
    d_cr0 = cr0we_tot - s_cr0; d_ov = ovwe_tot - s_ov; d_to = to_tot - s_to;
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ds, dr, dw, dc, dv, dt, tc;
    logic [2:0] ls;
    logic lst;

    //          op         a              b              rd     rc    oe    so    busy pre data           cr0      ov    stall req
    vecs[0] = '{OP_MULW,   32'd7,         32'hFFFFFFFD,  5'd3,  1'b1, 1'b0, 1'b0, 3,   0,  32'hFFFFFFEB,  4'b1000, 1'b0, 6,    1};
    vecs[1] = '{OP_DIVWU,  32'd100,       32'd7,         5'd4,  1'b0, 1'b1, 1'b0, 0,   0,  32'd14,        4'b0100, 1'b0, 3,    1};
    vecs[2] = '{OP_DIVWU,  32'd100,       32'd7,         5'd9,  1'b1, 1'b1, 1'b1, 0,   4,  32'd14,        4'b0101, 1'b0, 6,    4};
    vecs[3] = '{OP_DIVW,   32'hFFFFFF9C,  32'd7,         5'd31, 1'b1, 1'b1, 1'b1, 2,   0,  32'hFFFFFFF2,  4'b1001, 1'b0, 5,    1};
    vecs[4] = '{OP_DIVWU,  32'd5,         32'd0,         5'd1,  1'b1, 1'b1, 1'b0, 1,   0,  32'd0,         4'b0010, 1'b1, 4,    1};
    vecs[5] = '{OP_MULW,   32'h00010000,  32'h00010000,  5'd2,  1'b0, 1'b1, 1'b1, 2,   0,  32'd0,         4'b0011, 1'b1, 5,    1};
    vecs[6] = '{OP_MULHW,  32'hFFFFFFFE,  32'd3,         5'd17, 1'b1, 1'b0, 1'b0, 4,   0,  32'hFFFFFFFF,  4'b1000, 1'b0, 7,    1};
    vecs[7] = '{OP_MULHWU, 32'hFFFFFFFF,  32'd2,         5'd5,  1'b1, 1'b1, 1'b0, 1,   0,  32'd1,         4'b0100, 1'b0, 4,    1};

    rst = 1'b1; ex_valid = 1'b0; ex_op = OP_NOP; ex_a = '0; ex_b = '0; ex_rd = '0;
    ex_rc = 1'b0; ex_oe = 1'b0; flush = 1'b0; xer_so = 1'b0;
    ext_busy = 1'b0; cur_busy = 0; exp_a = '0; exp_b = '0; exp_op = OP_NOP;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check_reset_vals("reset");

    // Table of complete operations.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush on the second WAIT cycle: drain until ack, then idle, no write-back.
    run_seq(vecs[0], 0, 1000, 3, 3, 8, ds, dr, dw, dc, dv, dt, tc, ls, lst);
    chk("flush_wait_stall", 32'(ds), 32'd6);
    chk("flush_wait_req", 32'(dr), 32'd1);
    chk("flush_wait_wb", 32'(dw), 32'd0);
    chk("flush_wait_cr0we", 32'(dc), 32'd0);
    chk("flush_wait_ovwe", 32'(dv), 32'd0);
    chk("flush_wait_state", 32'(ls), 32'd0);
    chk("flush_wait_stall_end", 32'(lst), 32'd0);

    // Flush in the same cycle as completion: result discarded.
    run_seq(vecs[1], 0, 1000, 2, 2, 5, ds, dr, dw, dc, dv, dt, tc, ls, lst);
    chk("flush_done_stall", 32'(ds), 32'd3);
    chk("flush_done_wb", 32'(dw), 32'd0);
    chk("flush_done_ovwe", 32'(dv), 32'd0);
    chk("flush_done_state", 32'(ls), 32'd0);

    // Flush in REQ while the MDU is busy: request dropped.
    run_seq(vecs[1], 5, 1000, 1, 1, 6, ds, dr, dw, dc, dv, dt, tc, ls, lst);
    chk("flush_req_busy_stall", 32'(ds), 32'd2);
    chk("flush_req_busy_req", 32'(dr), 32'd1);
    chk("flush_req_busy_wb", 32'(dw), 32'd0);
    chk("flush_req_busy_state", 32'(ls), 32'd0);

    // Flush in REQ while the MDU accepts: drain the accepted op.
    run_seq(vecs[3], 0, 1000, 1, 1, 7, ds, dr, dw, dc, dv, dt, tc, ls, lst);
    chk("flush_req_ack_stall", 32'(ds), 32'd5);
    chk("flush_req_ack_wb", 32'(dw), 32'd0);
    chk("flush_req_ack_state", 32'(ls), 32'd0);

    // MDU never completes: timeout after 8 WAIT cycles.
    run_seq(vecs[1], 0, 2, -1, 10, 11, ds, dr, dw, dc, dv, dt, tc, ls, lst);
    chk("timeout_pulses", 32'(dt), 32'd1);
    chk("timeout_cycle", 32'(tc), 32'd9);
    chk("timeout_stall", 32'(ds), 32'd10);
    chk("timeout_wb", 32'(dw), 32'd0);
    chk("timeout_state", 32'(ls), 32'd0);

    // Reset in the middle of WAIT, then a fresh operation.
    @(posedge clk); #1;
    drive_ex(vecs[0]);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check_reset_vals("rst_mid");
    run_vec(vecs[7], "after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
